dmi_req_arb: RTL



---
 rtl/dmi_req_arb.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/dmi_req_arb.sv
`default_nettype none
// ============================================================================
//  Module   : dmi_req_arb
//  Purpose  : Round-robin arbiter that shares the single DMI request/response
//             port of the debug module CSR block between NumReq DMI sources.
//             Exactly one transaction is in flight at a time. The response is
//             returned only to the source that issued the request.
//  Options  : DMI_REQ_ARB_TIMEOUT_EN - when defined, a WAIT that lasts
//             TimeoutCycles cycles without a DM response ends with a
//             synthesized failed response (data 0, resp 2).
//  Revision : 1.0 - initial release
// ============================================================================
module dmi_req_arb #(
  parameter int NumReq        = 2,
  parameter int AddrWidth     = 7,
  parameter int TimeoutCycles = 1023
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           src_req_valid_i,
  output logic [NumReq-1:0]           src_req_ready_o,
  input  logic [NumReq*AddrWidth-1:0] src_req_addr_i,
  input  logic [NumReq*2-1:0]         src_req_op_i,
  input  logic [NumReq*32-1:0]        src_req_data_i,
  output logic [NumReq-1:0]           src_rsp_valid_o,
  input  logic [NumReq-1:0]           src_rsp_ready_i,
  output logic [31:0]                 src_rsp_data_o,
  output logic [1:0]                  src_rsp_resp_o,
  output logic                        dm_req_valid_o,
  input  logic                        dm_req_ready_i,
  output logic [AddrWidth-1:0]        dm_req_addr_o,
  output logic [1:0]                  dm_req_op_o,
  output logic [31:0]                 dm_req_data_o,
  input  logic                        dm_rsp_valid_i,
  output logic                        dm_rsp_ready_o,
  input  logic [31:0]                 dm_rsp_data_i,
  input  logic [1:0]                  dm_rsp_resp_i,
  output logic                        busy_o,
  output logic [$clog2(NumReq)-1:0]   owner_o
);

  localparam int            c_OW          = $clog2(NumReq);
  localparam logic [c_OW:0] c_NUM         = (c_OW+1)'(NumReq);
  localparam logic [1:0]    c_ST_IDLE     = 2'd0;
  localparam logic [1:0]    c_ST_ISSUE    = 2'd1;
  localparam logic [1:0]    c_ST_WAIT     = 2'd2;
  localparam logic [1:0]    c_ST_RESP     = 2'd3;
  localparam logic [1:0]    c_OP_NOP      = 2'd0;
  localparam logic [1:0]    c_RESP_FAILED = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [c_OW-1:0]      r_rr_ptr;
  logic [c_OW-1:0]      r_owner;
  logic [AddrWidth-1:0] r_addr;
  logic [1:0]           r_op;
  logic [31:0]          r_data;
  logic [31:0]          r_rsp_data;
  logic [1:0]           r_rsp_resp;

  logic                 w_any_valid;
  logic [c_OW:0]        w_cand;
  logic [c_OW-1:0]      w_gnt_idx;
  logic [AddrWidth-1:0] w_gnt_addr;
  logic [1:0]           w_gnt_op;
  logic [31:0]          w_gnt_data;
  logic [c_OW:0]        w_owner_inc;
  logic [c_OW-1:0]      w_rr_next;
  logic                 w_owner_rdy;
  logic                 w_tmo;

  assign w_any_valid = |src_req_valid_i;
  assign w_owner_rdy = src_rsp_ready_i[r_owner];

  // Pointer after the owner, wrapping at NumReq rather than at 2^width.
  assign w_owner_inc = {1'b0, r_owner} + (c_OW+1)'(1);
  assign w_rr_next   = (w_owner_inc >= c_NUM) ? '0 : w_owner_inc[c_OW-1:0];

  // Round-robin search: walk downward so the closest valid source at or above
  // rr_ptr (with wrap) is the last one written and therefore wins.
  always_comb begin
    w_cand    = '0;
    w_gnt_idx = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_rr_ptr} + (c_OW+1)'(k);
      if (w_cand >= c_NUM) begin
        w_cand = w_cand - c_NUM;
      end
      if (src_req_valid_i[w_cand[c_OW-1:0]]) begin
        w_gnt_idx = w_cand[c_OW-1:0];
      end
    end
  end

  // Select the granted source's request fields from the packed buses.
  always_comb begin
    w_gnt_addr = '0;
    w_gnt_op   = '0;
    w_gnt_data = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (c_OW'(i) == w_gnt_idx) begin
        w_gnt_addr = src_req_addr_i[i*AddrWidth +: AddrWidth];
        w_gnt_op   = src_req_op_i[i*2 +: 2];
        w_gnt_data = src_req_data_i[i*32 +: 32];
      end
    end
  end

`ifdef DMI_REQ_ARB_TIMEOUT_EN
  localparam logic [31:0] c_TMO_LAST = 32'(TimeoutCycles - 1);
  logic [31:0] r_tmo_cnt;

  // WAIT-cycle counter, cleared while issuing so it starts at zero in WAIT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tmo_cnt <= '0;
    end else if (r_state == c_ST_ISSUE) begin
      r_tmo_cnt <= '0;
    end else if (r_state == c_ST_WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end
  end

  // Fires in the WAIT cycle in which the count reaches TimeoutCycles.
  assign w_tmo = (r_state == c_ST_WAIT) && (r_tmo_cnt == c_TMO_LAST);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TimeoutCycles != 0);
  assign w_tmo        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_any_valid) w_next_state = c_ST_ISSUE;
      c_ST_ISSUE: if (dm_req_ready_i) w_next_state = (r_op == c_OP_NOP) ? c_ST_IDLE : c_ST_WAIT;
      c_ST_WAIT:  if (dm_rsp_valid_i || w_tmo) w_next_state = c_ST_RESP;
      c_ST_RESP:  if (w_owner_rdy) w_next_state = c_ST_IDLE;
      default:    w_next_state = c_ST_IDLE;
    endcase
  end

  // Request/response buffers, owner and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_addr     <= '0;
      r_op       <= '0;
      r_data     <= '0;
      r_rsp_data <= '0;
      r_rsp_resp <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_any_valid) begin
            r_owner <= w_gnt_idx;
            r_addr  <= w_gnt_addr;
            r_op    <= w_gnt_op;
            r_data  <= w_gnt_data;
          end
        end
        c_ST_WAIT: begin
          // A real response in the timeout cycle takes precedence.
          if (dm_rsp_valid_i) begin
            r_rsp_data <= dm_rsp_data_i;
            r_rsp_resp <= dm_rsp_resp_i;
          end else if (w_tmo) begin
            r_rsp_data <= '0;
            r_rsp_resp <= c_RESP_FAILED;
          end
        end
        c_ST_RESP: begin
          if (w_owner_rdy) begin
            r_rr_ptr <= w_rr_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; only the grant strobe looks at source inputs.
  always_comb begin
    src_req_ready_o = '0;
    src_rsp_valid_o = '0;
    if ((r_state == c_ST_IDLE) && w_any_valid && !rst_i) begin
      src_req_ready_o[w_gnt_idx] = 1'b1;
    end
    if (r_state == c_ST_RESP) begin
      src_rsp_valid_o[r_owner] = 1'b1;
    end
    dm_req_valid_o = (r_state == c_ST_ISSUE);
    dm_rsp_ready_o = (r_state == c_ST_WAIT);
    busy_o         = (r_state != c_ST_IDLE);
  end

  assign dm_req_addr_o  = r_addr;
  assign dm_req_op_o    = r_op;
  assign dm_req_data_o  = r_data;
  assign src_rsp_data_o = r_rsp_data;
  assign src_rsp_resp_o = r_rsp_resp;
  assign owner_o        = r_owner;

endmodule
`default_nettype wire
